idu_stage: RTL
==============

// Module: idu_stage
// PURPOSE
//  Registered, handshaked decode stage between the fetch unit and the execute unit.
//  Each fetched RV32I/RV64I word is decoded into the following fields:
//    - register addresses
//    - sign-extended immediate
//    - ALU op and control flags
//    - trap flags
//  Results are presented one cycle later under a valid/ready protocol.
//  A 2-entry skid buffer keeps full throughput under execute-side backpressure; flush empties the stage.
// PARAMETERS
//  XLEN        32  datapath width (32 or 64); sets immediate width, pc width and shamt legality
//  SKID_EN     1   1: 2-entry buffer, in_ready is registered; 0: 1 entry, in_ready = !out_valid | out_ready
// PORTS
//  clk          in   1      clock
//  rst          in   1      reset, asynchronous, active-high
//  flush        in   1      discard all held entries (redirect/trap)
//  in_valid     in   1      fetch presents in_inst/in_pc
//  in_ready     out  1      stage accepts this cycle
//  in_inst      in   32     instruction word
//  in_pc        in   XLEN   pc of in_inst
//  out_valid    out  1      decoded entry available
//  out_ready    in   1      execute consumes this cycle
//  out_pc       out  XLEN   pc of decoded entry
//  out_opcode   out  7      inst[6:0]
//  out_rd       out  5      destination; 0 for BRANCH/STORE
//  out_rs1      out  5      inst[19:15]; 0 for LUI/AUIPC/JAL
//  out_rs2      out  5      inst[24:20] for BRANCH/STORE/OP(-32); else 0
//  out_imm      out  XLEN   I/S/B/U/J immediate, sign-extended to XLEN; 0 for R-type
//  out_alu_op   out  5      ALU operation, encoding from idu_pkg
//  out_reg_we   out  1      rd written (0 if rd==0)
//  out_mem_rd   out  1      LOAD
//  out_mem_wr   out  1      STORE
//  out_csr      out  12     inst[31:20] for SYSTEM, else 0
//  out_ebreak   out  1      inst == 32'h00100073
//  out_ecall    out  1      inst == 32'h00000073
//  out_illegal  out  1      unknown opcode/funct, or illegal shamt
// BEHAVIOUR
//  Reset: all out_* fields = 0, out_valid=0, in_ready=1, FSM=EMPTY.
//  Transfer on valid&ready per side. Latency: accepted word appears at out_* the next cycle.
//  FSM (SKID_EN=1): EMPTY, ONE (main reg valid), TWO (main + skid valid).
//    EMPTY: in_fire -> ONE.
//    ONE:   in_fire & !out_fire -> TWO; out_fire & !in_fire -> EMPTY; both -> ONE, main reloads.
//    TWO:   in_ready=0; out_fire -> ONE, main <= skid.
//  in_ready = (state != TWO), driven from a register, with no combinational path from out_ready.
//  Ordering: entries leave in acceptance order; no entry is duplicated or dropped.
//  Decode is combinational on in_inst; only decoded fields are stored (never raw instruction).
//  Shamt legality:
//    XLEN=32: SLLI/SRLI/SRAI with inst[25]=1 -> out_illegal.
//    XLEN=64: inst[25] is legal; the *W forms require inst[25]=0.
//  Trap entries: out_illegal/ebreak/ecall still issue as normal entries, with reg_we=0.
//  flush: state -> EMPTY next cycle, out_valid=0.
//    A same-cycle in_fire is dropped.
//    Flush has priority over every other event.
//  Reset mid-transfer: entries are lost; no output is asserted until a new in_fire.
// STRUCTURE
//  idu_pkg holds:
//    - opcode constants
//    - ALU op enum (5-bit)
//    - immediate-type enum
//    - the decoded-entry struct width
//  Sub-module idu_decode (pure combinational inst -> entry) is instantiated once.
//  The buffer/FSM lives in idu_stage.
// TESTING
//  1. Reset, then in ADDI x1,x0,-1 (32'hfff00093) -> next cycle: out_imm=all ones, rd=1, rs1=0, reg_we=1.
//  2. Hold out_ready=0, feed 3 words -> third stalls (in_ready=0).
//     Then release -> order is preserved, no loss.
//  3. Stream 8 words with out_ready=1 -> one output per cycle, latency 1.
//  4. SLLI inst[25]=1 (32'h02009093): XLEN=32 -> out_illegal=1; XLEN=64 -> out_illegal=0.
//  5. Flush asserted while in TWO and with in_valid=1 -> out_valid=0 next cycle, nothing is emitted later.
//  6. 32'h00100073 -> out_ebreak=1, reg_we=0.
//     SW x2,4(x1) (32'h0020a223) -> rd=0, rs2=2, imm=4, mem_wr=1.

Source files
------------

// File: rtl/idu_pkg.sv
// Shared types for the instruction decode stage: opcodes, ALU operations,
// immediate formats, buffer states and the decoded control word.
package idu_pkg;

   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

   localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

   typedef enum logic [4:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
      ALU_OR, ALU_AND, ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW, ALU_LUI,
      ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU
   } alu_op_e;

   typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

   typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} stage_state_e;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      alu_op_e     alu_op;
      logic        reg_we;
      logic        mem_rd;
      logic        mem_wr;
      logic [11:0] csr;
      logic        ebreak;
      logic        ecall;
      logic        illegal;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

   // A held entry is {pc, imm, ctrl}; pc and imm scale with XLEN.
   function automatic int entry_w(int xlen);
      return CTRL_W + 2 * xlen;
   endfunction

   // alt selects SUB/SRA and is only meaningful for funct3 000/101.
   function automatic alu_op_e alu_op_from_f3(logic [2:0] f3, logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   function automatic alu_op_e alu_w_op_from_f3(logic [2:0] f3, logic alt);
      case (f3)
         3'b001:  return ALU_SLLW;
         3'b101:  return alt ? ALU_SRAW : ALU_SRLW;
         default: return alt ? ALU_SUBW : ALU_ADDW;
      endcase
   endfunction

   function automatic alu_op_e branch_op_from_f3(logic [2:0] f3);
      case (f3)
         3'b001:  return ALU_BNE;
         3'b100:  return ALU_BLT;
         3'b101:  return ALU_BGE;
         3'b110:  return ALU_BLTU;
         3'b111:  return ALU_BGEU;
         default: return ALU_BEQ;
      endcase
   endfunction

endpackage

// File: rtl/idu_if.sv
// Handshake bundles on either side of the decode stage: fetch -> stage and
// stage -> execute. The master drives valid and payload, the slave drives ready.
interface idu_fetch_if #(parameter int XLEN = 32);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_inst;
   logic [XLEN-1:0] in_pc;

   modport master (output in_valid, in_inst, in_pc, input in_ready);
   modport slave  (input in_valid, in_inst, in_pc, output in_ready);
endinterface

interface idu_exec_if import idu_pkg::*; #(parameter int XLEN = 32);
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [6:0]      out_opcode;
   logic [4:0]      out_rd;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic [XLEN-1:0] out_imm;
   alu_op_e         out_alu_op;
   logic            out_reg_we;
   logic            out_mem_rd;
   logic            out_mem_wr;
   logic [11:0]     out_csr;
   logic            out_ebreak;
   logic            out_ecall;
   logic            out_illegal;

   modport master (output out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2, out_imm,
                   out_alu_op, out_reg_we, out_mem_rd, out_mem_wr, out_csr, out_ebreak,
                   out_ecall, out_illegal, input out_ready);
   modport slave  (input out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2, out_imm,
                   out_alu_op, out_reg_we, out_mem_rd, out_mem_wr, out_csr, out_ebreak,
                   out_ecall, out_illegal, output out_ready);
endinterface

// File: rtl/idu_decode.sv
// Pure combinational RV32I/RV64I decoder: instruction word -> control word and
// sign-extended immediate.
module idu_decode import idu_pkg::*; #(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst,
   output ctrl_t           ctrl,
   output logic [XLEN-1:0] imm
);

   localparam bit RV64 = (XLEN == 64);

   logic [2:0]  f3;
   logic [6:0]  f7;
   logic        legal;
   logic        writes_rd;
   imm_type_e   imm_type;
   logic [31:0] imm32;

   assign f3 = inst[14:12];
   assign f7 = inst[31:25];

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      ctrl          = '0;
      ctrl.opcode   = inst[6:0];
      ctrl.rd       = inst[11:7];
      ctrl.rs1      = inst[19:15];
      ctrl.alu_op   = ALU_ADD;
      ctrl.ecall    = (inst == INST_ECALL);
      ctrl.ebreak   = (inst == INST_EBREAK);
      legal         = 1'b1;
      writes_rd     = 1'b0;
      imm_type      = IMM_NONE;

      case (inst[6:0])
         OPC_LUI:   begin imm_type = IMM_U; writes_rd = 1'b1; ctrl.rs1 = '0; ctrl.alu_op = ALU_LUI; end
         OPC_AUIPC: begin imm_type = IMM_U; writes_rd = 1'b1; ctrl.rs1 = '0; end
         OPC_JAL:   begin imm_type = IMM_J; writes_rd = 1'b1; ctrl.rs1 = '0; end
         OPC_JALR:  begin imm_type = IMM_I; writes_rd = 1'b1; legal = (f3 == 3'b000); end
         OPC_BRANCH: begin
            imm_type    = IMM_B;
            ctrl.rd     = '0;
            ctrl.rs2    = inst[24:20];
            ctrl.alu_op = branch_op_from_f3(f3);
            legal       = (f3[2:1] != 2'b01);
         end
         OPC_LOAD: begin
            imm_type    = IMM_I;
            writes_rd   = 1'b1;
            ctrl.mem_rd = 1'b1;
            legal       = (f3 != 3'b111) && (RV64 || (f3 != 3'b011 && f3 != 3'b110));
         end
         OPC_STORE: begin
            imm_type    = IMM_S;
            ctrl.rd     = '0;
            ctrl.rs2    = inst[24:20];
            ctrl.mem_wr = 1'b1;
            legal       = !f3[2] && (RV64 || f3 != 3'b011);
         end
         OPC_OP_IMM: begin
            imm_type    = IMM_I;
            writes_rd   = 1'b1;
            ctrl.alu_op = alu_op_from_f3(f3, (f3 == 3'b101) && inst[30]);
            // inst[25] is shamt bit 5: only meaningful on a 64-bit datapath.
            if (f3 == 3'b001)
               legal = (inst[31:26] == 6'b000000) && (RV64 || !inst[25]);
            else if (f3 == 3'b101)
               legal = (inst[31:26] == 6'b000000 || inst[31:26] == 6'b010000) && (RV64 || !inst[25]);
         end
         OPC_OP: begin
            writes_rd   = 1'b1;
            ctrl.rs2    = inst[24:20];
            ctrl.alu_op = alu_op_from_f3(f3, inst[30]);
            legal       = (f7 == 7'b0000000) || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
         end
         OPC_OP_IMM_32: begin
            imm_type    = IMM_I;
            writes_rd   = 1'b1;
            ctrl.alu_op = alu_w_op_from_f3(f3, (f3 == 3'b101) && inst[30]);
            legal       = RV64 && ((f3 == 3'b000) || (f3 == 3'b001 && f7 == 7'b0000000) ||
                                   (f3 == 3'b101 && (f7 == 7'b0000000 || f7 == 7'b0100000)));
         end
         OPC_OP_32: begin
            writes_rd   = 1'b1;
            ctrl.rs2    = inst[24:20];
            ctrl.alu_op = alu_w_op_from_f3(f3, inst[30]);
            legal       = RV64 && ((f7 == 7'b0000000 && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101)) ||
                                   (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
         end
         OPC_MISC_MEM: begin imm_type = IMM_I; legal = (f3 == 3'b000); end
         OPC_SYSTEM: begin
            imm_type  = IMM_I;
            ctrl.csr  = inst[31:20];
            writes_rd = (f3 != 3'b000);
            legal     = (f3 == 3'b000) ? (ctrl.ecall || ctrl.ebreak) : (f3 != 3'b100);
         end
         default: legal = 1'b0;
      endcase

      case (imm_type)
         IMM_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
         IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         IMM_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         IMM_U:   imm32 = {inst[31:12], 12'h000};
         IMM_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default: imm32 = '0;
      endcase

      // Trapping entries still issue, but never write a register or touch memory.
      ctrl.illegal = !legal;
      ctrl.reg_we  = writes_rd && legal && (ctrl.rd != 5'd0);
      ctrl.mem_rd  = ctrl.mem_rd && legal;
      ctrl.mem_wr  = ctrl.mem_wr && legal;
   end

   assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/idu_stage.sv
// Registered decode stage: decodes the fetched word and holds up to two decoded
// entries (main + skid) so in_ready never depends combinationally on out_ready.
module idu_stage import idu_pkg::*; #(
   parameter int XLEN    = 32,
   parameter bit SKID_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   idu_fetch_if.slave  fetch,
   idu_exec_if.master  exec
);

   localparam int ENTRY_W = entry_w(XLEN);

   ctrl_t              dec_ctrl;
   logic [XLEN-1:0]    dec_imm;
   logic [ENTRY_W-1:0] dec_entry;
   logic [ENTRY_W-1:0] main_q;
   logic [ENTRY_W-1:0] skid_q;
   ctrl_t              main_ctrl;
   stage_state_e       state_q;
   logic               out_valid_q;
   logic               in_ready_q;
   logic               in_fire;
   logic               out_fire;

   idu_decode #(.XLEN(XLEN)) u_decode (
      .inst (fetch.in_inst),
      .ctrl (dec_ctrl),
      .imm  (dec_imm)
   );

   assign dec_entry      = {fetch.in_pc, dec_imm, dec_ctrl};
   assign fetch.in_ready = SKID_EN ? in_ready_q : (!out_valid_q || exec.out_ready);
   assign in_fire        = fetch.in_valid && fetch.in_ready;
   assign out_fire       = out_valid_q && exec.out_ready;

   // With SKID_EN=0 in_fire in ONE implies out_fire, so TWO is never entered.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         // NOTE: entry registers are reset because they drive out_* directly and must read 0 after reset.
         main_q      <= '0;
         skid_q      <= '0;
      end else if (flush) begin
         state_q     <= ST_EMPTY;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         case (state_q)
            ST_EMPTY: if (in_fire) begin
               main_q      <= dec_entry;
               state_q     <= ST_ONE;
               out_valid_q <= 1'b1;
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  main_q <= dec_entry;
               end else if (in_fire) begin
                  skid_q     <= dec_entry;
                  state_q    <= ST_TWO;
                  in_ready_q <= 1'b0;
               end else if (out_fire) begin
                  state_q     <= ST_EMPTY;
                  out_valid_q <= 1'b0;
               end
            end
            ST_TWO: if (out_fire) begin
               main_q     <= skid_q;
               state_q    <= ST_ONE;
               in_ready_q <= 1'b1;
            end
            default: begin
               state_q     <= ST_EMPTY;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign main_ctrl        = main_q[CTRL_W-1:0];
   assign exec.out_valid   = out_valid_q;
   assign exec.out_imm     = main_q[CTRL_W +: XLEN];
   assign exec.out_pc      = main_q[CTRL_W+XLEN +: XLEN];
   assign exec.out_opcode  = main_ctrl.opcode;
   assign exec.out_rd      = main_ctrl.rd;
   assign exec.out_rs1     = main_ctrl.rs1;
   assign exec.out_rs2     = main_ctrl.rs2;
   assign exec.out_alu_op  = main_ctrl.alu_op;
   assign exec.out_reg_we  = main_ctrl.reg_we;
   assign exec.out_mem_rd  = main_ctrl.mem_rd;
   assign exec.out_mem_wr  = main_ctrl.mem_wr;
   assign exec.out_csr     = main_ctrl.csr;
   assign exec.out_ebreak  = main_ctrl.ebreak;
   assign exec.out_ecall   = main_ctrl.ecall;
   assign exec.out_illegal = main_ctrl.illegal;

endmodule
